// File: rtl/jk_cmd_seq.sv
// Command sequencer feeding a JK flop: FIFO of {op,len} commands, each driving j/k for len+1 cycles.
// Optional flop-output checker against an internal JK model when JK_CHECK_EN is defined.
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [CNT_W-1:0] cmd_len_i,
   output logic             j_o,
   output logic             k_o,
   input  logic             q_in_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [1:0]       op;
      logic [CNT_W-1:0] len;
   } cmd_t;

   typedef enum logic {S_IDLE, S_DRIVE} state_e;

   cmd_t            mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [CW-1:0]   count_q, count_d;
   state_e          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            j_q, j_d, k_q, k_d, done_q, done_d;
   logic            push, pop, empty, full;
   cmd_t            head;

   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(DEPTH));
   assign cmd_ready_o = !full;
   assign push        = cmd_valid_i && !full;
   assign head        = mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= '{op: cmd_op_i, len: cmd_len_i};
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
   end

   // On the last drive cycle the next command is popped in the same edge so j/k never bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      j_d     = j_q;
      k_d     = k_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               {j_d, k_d} = head.op;
               cnt_d      = head.len;
               state_d    = S_DRIVE;
            end else begin
               j_d = 1'b0;
               k_d = 1'b0;
            end
         end
         S_DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               done_d = 1'b1;
               if (!empty) begin
                  pop        = 1'b1;
                  {j_d, k_d} = head.op;
                  cnt_d      = head.len;
               end else begin
                  j_d     = 1'b0;
                  k_d     = 1'b0;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         count_q <= count_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         done_q  <= done_d;
      end
   end

   assign j_o    = j_q;
   assign k_o    = k_q;
   assign done_o = done_q;
   assign busy_o = (state_q == S_DRIVE) || !empty;

`ifdef JK_CHECK_EN
   // qm tracks what the flop should hold after each edge; checking starts once a SET/CLEAR fixes it.
   logic qm_q, mv_q, err_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         qm_q  <= 1'b0;
         mv_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (mv_q && (q_in_i != qm_q)) err_q <= 1'b1;
         if (j_q || k_q)               qm_q  <= (j_q && k_q) ? ~qm_q : j_q;
         if (j_q ^ k_q)                mv_q  <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_q_in;
   assign unused_q_in = q_in_i;
   assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Bench for jk_cmd_seq: directed vector table, corner-case sequences and random traffic
// checked against a schedule-based reference model of command start/end cycles.
module tb_jk_cmd_seq;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'b00;
   logic [7:0] cmd_len = 8'd0;
   logic       j, k, q_in, busy, done, err;
   logic       q_flop = 1'b0;
   logic       bad = 1'b0;

   jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(8)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_len_i(cmd_len), .j_o(j), .k_o(k), .q_in_i(q_in),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   // Behavioural JK flop downstream of the sequencer.
   always @(posedge clk) q_flop <= j ? (k ? ~q_flop : 1'b1) : (k ? 1'b0 : q_flop);
   assign q_in = q_flop ^ bad;

   // Reference: each accepted command occupies drive cycles [s, e]; cycle c is the interval after edge c.
   typedef struct {
      int         acc;
      int         s;
      int         e;
      logic [1:0] op;
   } mcmd_t;

   mcmd_t mq[$];
   int    e_prev;
   int    cyc;
   int    n_cmp = 0;
   int    n_bad = 0;
   int    done_cnt;
   logic  err_exp;

   function automatic logic [1:0] m_jk(int c);
      foreach (mq[i]) if (mq[i].s <= c && c <= mq[i].e) return mq[i].op;
      return 2'b00;
   endfunction

   function automatic logic m_done(int c);
      foreach (mq[i]) if (mq[i].e + 1 == c) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_busy(int c);
      foreach (mq[i]) if (mq[i].acc <= c && c <= mq[i].e) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic m_ready(int c);
      int n = 0;
      foreach (mq[i]) if (mq[i].acc <= c && c < mq[i].s) n++;
      return n < DEPTH;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input logic v, input logic [1:0] op, input logic [7:0] len, output logic acc);
      logic  rdy;
      mcmd_t m;
      rdy       = m_ready(cyc);
      cmd_valid = v;
      cmd_op    = op;
      cmd_len   = len;
      @(posedge clk);
      cyc++;
      acc = v && rdy;
      if (acc) begin
         m.acc  = cyc;
         m.s    = (cyc + 1 > e_prev + 1) ? cyc + 1 : e_prev + 1;
         m.e    = m.s + int'(len);
         m.op   = op;
         e_prev = m.e;
         mq.push_back(m);
      end
      #1;
      chk("jk", {30'd0, j, k}, {30'd0, m_jk(cyc)});
      chk("done", {31'd0, done}, {31'd0, m_done(cyc)});
      chk("busy", {31'd0, busy}, {31'd0, m_busy(cyc)});
      chk("ready", {31'd0, cmd_ready}, {31'd0, m_ready(cyc)});
      chk("err", {31'd0, err}, {31'd0, err_exp});
      done_cnt += int'(done);
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      mq.delete();
      e_prev   = -100;
      cyc      = 0;
      err_exp  = 1'b0;
      done_cnt = 0;
      chk("rst_jk", {30'd0, j, k}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic       v;
      logic [1:0] op;
      logic [7:0] len;
      logic       j, k, d, b;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      logic a;
      int   tries;
      logic saw_full;
      logic [4:0] qexp;

      // SET len=0, then CLEAR len=2 + TOGGLE len=1 back-to-back
      tbl[0]  = '{1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 2'b01, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 2'b11, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6]  = '{1'b0, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 2'b00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 2'b00, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         tick(tbl[i].v, tbl[i].op, tbl[i].len, a);
         chk($sformatf("tbl%0d_jk", i), {30'd0, j, k}, {30'd0, tbl[i].j, tbl[i].k});
         chk($sformatf("tbl%0d_done", i), {31'd0, done}, {31'd0, tbl[i].d});
         chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
      end

      // FIFO fills behind a long command; stalled pushes retry until accepted.
      do_reset();
      saw_full = 1'b0;
      tick(1'b1, 2'b10, 8'd15, a);
      for (int n = 0; n < 5; n++) begin
         tries = 0;
         do begin
            tick(1'b1, 2'(n), 8'(n), a);
            if (!cmd_ready) saw_full = 1'b1;
            tries++;
         end while (!a && tries < 100);
         chk("push_accepted", {31'd0, a}, 32'd1);
      end
      chk("saw_full", {31'd0, saw_full}, 32'd1);
      repeat (40) tick(1'b0, 2'b00, 8'd0, a);
      chk("done_count", done_cnt, 32'd6);

      // Async reset mid-DRIVE clears outputs without a clock edge.
      do_reset();
      tick(1'b1, 2'b10, 8'd10, a);
      repeat (3) tick(1'b0, 2'b00, 8'd0, a);
      chk("pre_rst_j", {31'd0, j}, 32'd1);
      do_reset();
      repeat (4) tick(1'b0, 2'b00, 8'd0, a);

      // Random traffic against the schedule model.
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         tick(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 3)), a);
      end
      repeat (60) tick(1'b0, 2'b00, 8'd0, a);

`ifdef JK_CHECK_EN
      // SET then TOGGLE len=3: flop follows 1,0,1,0,1; then one corrupted sample latches err.
      do_reset();
      qexp = 5'b10101;
      tick(1'b1, 2'b10, 8'd0, a);
      tick(1'b1, 2'b11, 8'd3, a);
      for (int n = 0; n < 5; n++) begin
         tick(1'b0, 2'b00, 8'd0, a);
         chk("q_follow", {31'd0, q_flop}, {31'd0, qexp[4-n]});
      end
      bad     = 1'b1;
      err_exp = 1'b1;
      tick(1'b0, 2'b00, 8'd0, a);
      bad = 1'b0;
      repeat (3) tick(1'b0, 2'b00, 8'd0, a);

      // TOGGLE-only traffic before any SET/CLEAR never flags.
      do_reset();
      for (int n = 0; n < 6; n++) tick(1'b1, 2'b11, 8'd1, a);
      bad = 1'b1;
      repeat (4) tick(1'b0, 2'b00, 8'd0, a);
      bad = 1'b0;
      repeat (4) tick(1'b0, 2'b00, 8'd0, a);
`else
      qexp = 5'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
